// File: rtl/wallace_final_adder.sv
// Final carry-propagate adder for the 32-bit Wallace multiplier.
// Adds the last carry-save pair one CHUNK_W-bit slice per pipeline stage.
// Operand bits not yet added travel down the pipe with the partial result.
// Each stage has valid/ready handshaking, and a reservation-station tag travels with every operation.
module wallace_final_adder #(
    parameter int CHUNK_W = 16,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [62:0]      sum_vec,
    input  logic [59:0]      carry_vec,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      product,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NSTG = 64 / CHUNK_W;

    // z_q holds the result slices completed so far in its top bits and the
    // unconsumed sum-vector bits in its bottom bits. It rotates right by one
    // slice per stage, so the last stage holds the product in natural order.
    logic [NSTG-1:0]  vld_q;
    logic [63:0]      z_q   [NSTG];
    logic [63:0]      b_q   [NSTG];
    logic             cy_q  [NSTG];
    logic [TAG_W-1:0] tag_q [NSTG];

    logic [NSTG:0]    adv;

    logic [63:0]      z_src   [NSTG];
    logic [63:0]      b_src   [NSTG];
    logic             cin_src [NSTG];
    logic [NSTG-1:0]  v_src;
    logic [TAG_W-1:0] tag_src [NSTG];
    logic [CHUNK_W:0] slice   [NSTG];
    logic [63:0]      z_nxt   [NSTG];
    logic [63:0]      b_nxt   [NSTG];

    // A stage may advance when it or any stage after it is empty,
    // or when the consumer takes the product. This collapses bubbles.
    assign adv[NSTG] = out_ready;
    for (genvar k = 0; k < NSTG; k++) begin : g_adv
        assign adv[k] = out_ready | ~(&vld_q[NSTG-1:k]);
    end

    assign in_ready  = adv[0] & ~reset & ~flush;
    assign out_valid = vld_q[NSTG-1];
    assign product   = z_q[NSTG-1];
    assign out_tag   = tag_q[NSTG-1];

    // Select each stage's source: the input port for stage 0, otherwise the registers of the previous stage.
    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            z_src[k]   = '0;
            b_src[k]   = '0;
            cin_src[k] = 1'b0;
            tag_src[k] = '0;
        end
        v_src = '0;
        z_src[0]   = {1'b0, sum_vec};
        b_src[0]   = {4'b0, carry_vec};
        cin_src[0] = 1'b0;
        v_src[0]   = in_valid & in_ready;
        tag_src[0] = in_tag;
        for (int k = 1; k < NSTG; k++) begin
            z_src[k]   = z_q[k-1];
            b_src[k]   = b_q[k-1];
            cin_src[k] = cy_q[k-1];
            v_src[k]   = vld_q[k-1];
            tag_src[k] = tag_q[k-1];
        end
    end

    // Add one slice per stage, then rotate the finished slice into the top of the word.
    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            slice[k] = {1'b0, z_src[k][CHUNK_W-1:0]}
                     + {1'b0, b_src[k][CHUNK_W-1:0]}
                     + {{CHUNK_W{1'b0}}, cin_src[k]};
            z_nxt[k] = 64'({slice[k][CHUNK_W-1:0], z_src[k]} >> CHUNK_W);
            b_nxt[k] = b_src[k] >> CHUNK_W;
        end
    end

    // Pipeline registers. Reset clears everything; flush clears only the valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTG; k++) begin
                vld_q[k] <= 1'b0;
                z_q[k]   <= '0;
                b_q[k]   <= '0;
                cy_q[k]  <= 1'b0;
                tag_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (flush) begin
                    vld_q[k] <= 1'b0;
                end else if (adv[k]) begin
                    vld_q[k] <= v_src[k];
                end
                if (adv[k]) begin
                    z_q[k]   <= z_nxt[k];
                    b_q[k]   <= b_nxt[k];
                    cy_q[k]  <= slice[k][CHUNK_W];
                    tag_q[k] <= tag_src[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_wallace_final_adder.sv
// Self-checking bench for wallace_final_adder.
// A scoreboard queue receives the expected result whenever an input is accepted.
// Each result is popped and compared when the adder presents its output.
module tb_wallace_final_adder;

    localparam int CHUNK_W = 16;
    localparam int TAG_W   = 4;
    localparam int NSTG    = 64 / CHUNK_W;

    typedef struct {
        logic [62:0]      s;
        logic [59:0]      c;
        logic [TAG_W-1:0] tag;
        logic [63:0]      p;
    } vec_t;

    typedef struct {
        logic [63:0]      p;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } sb_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [62:0]      sum_vec;
    logic [59:0]      carry_vec;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      product;
    logic [TAG_W-1:0] out_tag;

    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    bit          lat_check = 1'b0;
    logic [63:0] cur_exp   = '0;
    sb_t         sb[$];
    vec_t        tbl[8];
    logic [62:0] ops_s[5];
    logic [59:0] ops_c[5];

    wallace_final_adder #(.CHUNK_W(CHUNK_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum_vec(sum_vec), .carry_vec(carry_vec), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [62:0] s, input logic [59:0] c);
        return {1'b0, s} + {4'b0, c};
    endfunction

    function automatic logic [62:0] rnd_s();
        return 63'({$urandom(), $urandom()});
    endfunction

    function automatic logic [59:0] rnd_c();
        return 60'({$urandom(), $urandom()}) & ~60'h1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [62:0] s, input logic [59:0] c,
                                 input logic [TAG_W-1:0] t, input logic [63:0] exp);
        in_valid  = v;
        sum_vec   = s;
        carry_vec = c;
        in_tag    = t;
        cur_exp   = exp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, '0, '0);
    endtask

    task automatic drain();
        int n = 0;
        idle();
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 40) begin
            tick();
            n++;
        end
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: compare outputs against queued expectations, then log new accepts.
    always @(negedge clk) begin
        sb_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got product %0h tag %0h expected none", product, out_tag);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_product", product, e.p);
                checkOutput("sb_tag", 64'(out_tag), 64'(e.tag));
                if (lat_check) checkOutput("sb_latency", 64'(cyc - e.cyc), 64'(NSTG));
            end
        end
        if (in_valid && in_ready) sb.push_back('{cur_exp, in_tag, cyc});
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [62:0] s;
        logic [59:0] c;

        tbl[0] = '{63'h0000_FFFF_FFFF_FFFF, 60'h1,                  4'd3,  64'h0001_0000_0000_0000};
        tbl[1] = '{63'h7FFF_FFFF_FFFF_FFFF, 60'hFFF_FFFF_FFFF_FFFF, 4'd5,  64'h8FFF_FFFF_FFFF_FFFE};
        tbl[2] = '{63'h0,                   60'h0,                  4'd0,  64'h0};
        tbl[3] = '{63'h0000_0000_FFFF_FFFE, 60'h2,                  4'd7,  64'h0000_0001_0000_0000};
        tbl[4] = '{63'h1234_5678_9ABC_DEF0, 60'hFED_CBA9_8765_4320, 4'd9,  64'h2222_2222_2222_2210};
        tbl[5] = '{63'h5555_5555_5555_5555, 60'hAAA_AAAA_AAAA_AAAA, 4'd10, 64'h5FFF_FFFF_FFFF_FFFF};
        tbl[6] = '{63'h0000_0000_0000_8000, 60'h8000,               4'd12, 64'h0000_0000_0001_0000};
        tbl[7] = '{63'h7FFF_0000_0000_0000, 60'h001_0000_0000_0000, 4'd15, 64'h8000_0000_0000_0000};

        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle();

        // Reset state
        tick();
        @(negedge clk);
        checkOutput("reset_product", product, 64'd0);
        checkOutput("reset_tag", 64'(out_tag), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Carry ripple through every slice, exact latency
        lat_check = 1'b1;
        tick();
        applyStimulus(1'b1, tbl[0].s, tbl[0].c, tbl[0].tag, tbl[0].p);
        @(negedge clk);
        checkOutput("ripple_accept", 64'(in_ready), 64'd1);
        for (int i = 1; i < NSTG; i++) begin
            tick();
            idle();
            @(negedge clk);
            checkOutput("ripple_early_valid", 64'(out_valid), 64'd0);
        end
        tick();
        @(negedge clk);
        checkOutput("ripple_valid", 64'(out_valid), 64'd1);
        checkOutput("ripple_product", product, 64'h0001_0000_0000_0000);
        checkOutput("ripple_tag", 64'(out_tag), 64'd3);
        drain();

        // Table vectors back to back
        for (int i = 0; i < 8; i++) begin
            tick();
            applyStimulus(1'b1, tbl[i].s, tbl[i].c, tbl[i].tag, tbl[i].p);
            @(negedge clk);
            checkOutput("table_accept", 64'(in_ready), 64'd1);
        end
        drain();

        // Tags 1..4 on consecutive cycles
        for (int i = 1; i <= 4; i++) begin
            tick();
            s = rnd_s();
            c = rnd_c();
            applyStimulus(1'b1, s, c, 4'(i), model(s, c));
            @(negedge clk);
            checkOutput("b2b_accept", 64'(in_ready), 64'd1);
        end
        drain();

        // Backpressure: fill while stalled, hold, then release
        lat_check = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ops_s[i] = rnd_s();
            ops_c[i] = rnd_c();
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            out_ready = 1'b0;
            applyStimulus(1'b1, ops_s[i], ops_c[i], 4'(i + 1), model(ops_s[i], ops_c[i]));
            @(negedge clk);
            checkOutput("fill_in_ready", 64'(in_ready), 64'd1);
        end
        for (int j = 0; j < 3; j++) begin
            tick();
            applyStimulus(1'b1, ops_s[4], ops_c[4], 4'd5, model(ops_s[4], ops_c[4]));
            @(negedge clk);
            checkOutput("full_in_ready", 64'(in_ready), 64'd0);
            checkOutput("stall_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_product", product, model(ops_s[0], ops_c[0]));
            checkOutput("stall_tag", 64'(out_tag), 64'd1);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);
        drain();

        // Flush with three in flight and a simultaneous input
        lat_check = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            s = rnd_s();
            c = rnd_c();
            applyStimulus(1'b1, s, c, 4'(i + 8), model(s, c));
            @(negedge clk);
            checkOutput("preflush_accept", 64'(in_ready), 64'd1);
        end
        tick();
        s = rnd_s();
        c = rnd_c();
        applyStimulus(1'b1, s, c, 4'd11, model(s, c));
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        sb.delete();
        s = rnd_s();
        c = rnd_c();
        applyStimulus(1'b1, s, c, 4'd6, model(s, c));
        @(negedge clk);
        checkOutput("postflush_accept", 64'(in_ready), 64'd1);
        checkOutput("postflush_no_valid", 64'(out_valid), 64'd0);
        for (int i = 1; i < NSTG; i++) begin
            tick();
            idle();
            @(negedge clk);
            checkOutput("postflush_no_valid", 64'(out_valid), 64'd0);
        end
        tick();
        @(negedge clk);
        checkOutput("postflush_valid", 64'(out_valid), 64'd1);
        checkOutput("postflush_product", product, model(s, c));
        checkOutput("postflush_tag", 64'(out_tag), 64'd6);
        drain();

        // Reset together with flush, two operations in flight
        for (int i = 0; i < 2; i++) begin
            tick();
            s = rnd_s();
            c = rnd_c();
            applyStimulus(1'b1, s, c, 4'(i + 12), model(s, c));
            @(negedge clk);
        end
        tick();
        applyStimulus(1'b1, rnd_s(), rnd_c(), 4'd14, '0);
        reset = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        sb.delete();
        idle();
        @(negedge clk);
        checkOutput("rst_product", product, 64'd0);
        checkOutput("rst_tag", 64'(out_tag), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_hold_in_ready", 64'(in_ready), 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_release_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_no_stale", 64'(out_valid), 64'd0);
        for (int i = 0; i < NSTG + 2; i++) begin
            tick();
            @(negedge clk);
            checkOutput("rst_no_stale", 64'(out_valid), 64'd0);
        end

        // Random traffic with random backpressure
        lat_check = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                s = rnd_s();
                c = rnd_c();
                applyStimulus(1'b1, s, c, 4'(i), model(s, c));
            end else begin
                idle();
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
